// File: rtl/aura_pkg.sv
// Shared AURA datapath types: tile-buffer read modes and the Q/O row vector widths.
package aura_pkg;

  typedef enum logic {
    BUF_PARALLEL = 1'b0,
    BUF_DRAIN    = 1'b1
  } BUF_MODE_E;

  localparam int NUM_PES  = 16;
  localparam int HEAD_DIM = 32;
  localparam int ELEM_W   = 16;

  typedef logic [HEAD_DIM*ELEM_W-1:0] Q_VECTOR_T;
  typedef logic [HEAD_DIM*ELEM_W-1:0] O_VECTOR_T;

  // One buffer row has to hold either a Q or an O vector.
  localparam int ROW_W_DEFAULT = ($bits(Q_VECTOR_T) > $bits(O_VECTOR_T)) ?
                                 $bits(Q_VECTOR_T) : $bits(O_VECTOR_T);

endpackage

// File: rtl/tile_bank.sv
// One tile bank: the row array, its write port, and the full flag and row count.
// The full flag is set by a closing write and cleared by a read release.
module tile_bank
  import aura_pkg::*;
#(
  parameter int ROW_W  = ROW_W_DEFAULT,
  parameter int DEPTH  = NUM_PES,
  localparam int CNT_W  = $clog2(DEPTH+1),
  localparam int RIDX_W = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [RIDX_W-1:0]        wr_row_i,
  input  logic [ROW_W-1:0]         wr_data_i,
  input  logic                     set_full_i,
  input  logic [CNT_W-1:0]         set_count_i,
  input  logic                     release_i,
  output logic                     full_o,
  output logic [CNT_W-1:0]         count_o,
  output logic [DEPTH*ROW_W-1:0]   rows_o
);

  logic [ROW_W-1:0] mem_q [DEPTH];
  logic             full_q, full_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[wr_row_i] <= wr_data_i;
  end

  // A bank is never closed and released in the same cycle: writes need !full, releases need full.
  always_comb begin
    full_d  = full_q;
    count_d = count_q;
    if (set_full_i) begin
      full_d  = 1'b1;
      count_d = set_count_i;
    end else if (release_i) begin
      full_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full_q  <= 1'b0;
      count_q <= '0;
    end else begin
      full_q  <= full_d;
      count_q <= count_d;
    end
  end

  for (genvar r = 0; r < DEPTH; r++) begin : g_row
    assign rows_o[r*ROW_W +: ROW_W] = mem_q[r];
  end

  assign full_o  = full_q;
  assign count_o = count_q;

endmodule

// File: rtl/pingpong_tile_buffer.sv
// Two-bank ping-pong tile buffer: row-wise fill with short-tile closure, and either
// whole-bank parallel read or row-serial drain read, both behind valid/ready.
module pingpong_tile_buffer
  import aura_pkg::*;
#(
  parameter int        ROW_W = ROW_W_DEFAULT,
  parameter int        DEPTH = NUM_PES,
  parameter BUF_MODE_E MODE  = BUF_PARALLEL,
  localparam int       RD_W  = (MODE == BUF_PARALLEL) ? DEPTH*ROW_W : ROW_W,
  localparam int       CNT_W = $clog2(DEPTH+1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ROW_W-1:0]  wr_data,
  input  logic              wr_last,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [RD_W-1:0]   rd_data,
  output logic [CNT_W-1:0]  rd_rows,
  output logic              rd_last,
  output logic [1:0]        bank_full
);

  localparam int RIDX_W = $clog2(DEPTH);

  logic                   wr_bank_q, wr_bank_d;
  logic [RIDX_W-1:0]      wr_row_q, wr_row_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [1:0]             full;
  logic [CNT_W-1:0]       count [2];
  logic [DEPTH*ROW_W-1:0] rows [2];
  logic                   wr_fire, wr_close, rd_fire, rd_release;
  logic [CNT_W-1:0]       rd_count;
  logic [DEPTH*ROW_W-1:0] rd_bank_rows;

  assign wr_ready     = !full[wr_bank_q];
  assign wr_fire      = wr_valid && wr_ready;
  assign wr_close     = wr_fire && (wr_last || (wr_row_q == RIDX_W'(DEPTH-1)));
  assign rd_valid     = full[rd_bank_q];
  assign rd_fire      = rd_valid && rd_ready;
  assign rd_count     = count[rd_bank_q];
  assign rd_bank_rows = rows[rd_bank_q];
  assign rd_rows      = rd_valid ? rd_count : '0;
  assign bank_full    = full;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tile_bank #(
      .ROW_W (ROW_W),
      .DEPTH (DEPTH)
    ) u_bank (
      .clock       (clock),
      .reset       (reset),
      .wr_en_i     (wr_fire && (wr_bank_q == 1'(b))),
      .wr_row_i    (wr_row_q),
      .wr_data_i   (wr_data),
      .set_full_i  (wr_close && (wr_bank_q == 1'(b))),
      .set_count_i (CNT_W'(wr_row_q) + CNT_W'(1)),
      .release_i   (rd_release && (rd_bank_q == 1'(b))),
      .full_o      (full[b]),
      .count_o     (count[b]),
      .rows_o      (rows[b])
    );
  end

  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    rd_bank_d = rd_bank_q;
    if (wr_fire) begin
      if (wr_close) begin
        wr_bank_d = !wr_bank_q;
        wr_row_d  = '0;
      end else begin
        wr_row_d  = wr_row_q + RIDX_W'(1);
      end
    end
    if (rd_release) rd_bank_d = !rd_bank_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_bank_q <= 1'b0;
      wr_row_q  <= '0;
      rd_bank_q <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  if (MODE == BUF_PARALLEL) begin : g_par
    // Rows beyond the closing row of a short tile hold stale data and are masked to zero.
    always_comb begin
      rd_data = '0;
      for (int r = 0; r < DEPTH; r++) begin
        if (rd_valid && (CNT_W'(r) < rd_count))
          rd_data[r*ROW_W +: ROW_W] = rd_bank_rows[r*ROW_W +: ROW_W];
      end
    end
    assign rd_last    = 1'b0;
    assign rd_release = rd_fire;
  end else begin : g_drain
    logic [RIDX_W-1:0] rd_row_q, rd_row_d;

    assign rd_last    = rd_valid && (CNT_W'(rd_row_q) == (rd_count - CNT_W'(1)));
    assign rd_data    = rd_valid ? rd_bank_rows[rd_row_q*ROW_W +: ROW_W] : '0;
    assign rd_release = rd_fire && rd_last;

    always_comb begin
      rd_row_d = rd_row_q;
      if (rd_fire) rd_row_d = rd_last ? '0 : rd_row_q + RIDX_W'(1);
    end

    always_ff @(posedge clock) begin
      if (reset) rd_row_q <= '0;
      else       rd_row_q <= rd_row_d;
    end
  end

endmodule

// File: doc/pingpong_tile_buffer.md
# pingpong_tile_buffer

Parametrised two-bank (ping-pong) tile buffer that unifies and extends the Q-tile and O-tile SRAM wrappers in the AURA FlashAttention datapath. The write side accepts one row per handshake from the memory controller or the PE array. The read side is configured per instance: it can present a whole bank in parallel (Q tiles to the PEs) or drain it row-serially (O tiles to memory). Beyond the fixed wrappers it adds:
- short-tile closure via `wr_last`;
- per-bank row counts;
- a valid/ready handshake on both sides.

## Interface
- `ROW_W`, 512: bits per row (one Q/O vector).
- `DEPTH`, 16: rows per bank (normally `NUM_PES`). Must be ≥2.
- `MODE`, `BUF_PARALLEL`: `BUF_PARALLEL` reads the whole bank per handshake; `BUF_DRAIN` reads one row per handshake.
- Derived `RD_W`: `DEPTH*ROW_W` if `BUF_PARALLEL`, otherwise `ROW_W`.
- Derived `CNT_W`: `$clog2(DEPTH+1)`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `wr_valid` in 1: write row offered.
- `wr_ready` out 1: fill bank can accept a row.
- `wr_data` in `ROW_W`: row data.
- `wr_last` in 1: sampled with the write handshake; closes the fill bank after this row.
- `rd_valid` out 1: read bank full and presentable.
- `rd_ready` in 1: consumer accepts.
- `rd_data` out `RD_W`: bank (parallel mode) or current row (drain mode).
- `rd_rows` out `CNT_W`: valid row count of the read bank.
- `rd_last` out 1: drain mode only, current row is the bank's final row. Tied 0 in parallel mode.
- `bank_full` out 2: per-bank full flags, for debug/perf.

## Operation
- State:
  - 2 banks × `DEPTH` rows, held in flops;
  - `full[1:0]` and `count[b]` (`CNT_W`);
  - `wr_bank` and `wr_row`;
  - `rd_bank` and `rd_row` (`rd_row` is used in drain mode only).
- Write:
  - `wr_ready = !full[wr_bank]`.
  - On `wr_valid && wr_ready`, store the row at `mem[wr_bank][wr_row]`.
  - If `wr_row == DEPTH-1` or `wr_last`: set `full[wr_bank]`, set `count[wr_bank] = wr_row+1`, clear `wr_row`, and toggle `wr_bank`.
  - Otherwise increment `wr_row`.
- Read:
  - `rd_valid = full[rd_bank]`.
  - `rd_rows = rd_valid ? count[rd_bank] : 0`.
- Parallel mode:
  - `rd_data` is row `r` of `rd_bank` at bits `[r*ROW_W +: ROW_W]`.
  - Rows with `r >= count` read as 0.
  - On handshake: clear `full[rd_bank]` and toggle `rd_bank`.
- Drain mode:
  - `rd_data = mem[rd_bank][rd_row]`.
  - `rd_last = rd_valid && (rd_row == count[rd_bank]-1)`.
  - On handshake with `rd_last`: clear full, clear `rd_row`, and toggle `rd_bank`.
  - On any other handshake: increment `rd_row`.
- `rd_data` is forced to 0 whenever `!rd_valid`.
- Banks always alternate, so the read order equals the fill order.
- A bank must never be written while full or read while not full.

## Timing
- Reset values:
  - outputs: `wr_ready=1`, `rd_valid=0`, `rd_data=0`, `rd_rows=0`, `rd_last=0`, `bank_full=0`;
  - internal: pointers and counts 0. Memory contents are not reset.
- Reset mid-operation discards all buffered rows. The next cycle behaves as post-reset.
- Write-to-read latency: a bank-closing write at edge t gives `rd_valid=1` after edge t (one cycle). `rd_data` is combinational from the flops.
- Full: both banks full gives `wr_ready=0`. `wr_data` is ignored while `wr_ready=0`.
- Simultaneous release and write:
  - Reading releases bank B in the same cycle a write targets full bank B: the write stalls that cycle (`wr_ready` is from registered state). It proceeds next cycle.
  - Simultaneous close of bank A and release of bank B is legal and independent.
- Wrap-around: `wr_bank` and `rd_bank` toggle modulo 2. There is no empty-bank skip.
- `wr_last` on row 0 gives a 1-row bank.
- `wr_last` on row `DEPTH-1` is redundant and behaves the same as without it.
- Throughput:
  - write: 1 row/cycle;
  - parallel read: 1 bank/cycle;
  - drain read: 1 row/cycle, with no bubble at bank switch.

## Structure
- Shared package `aura_pkg`: enum `BUF_MODE_E {BUF_PARALLEL, BUF_DRAIN}`, plus the `ROW_W` default derived from the `Q_VECTOR_T`/`O_VECTOR_T` widths and `NUM_PES`.
- Sub-module `tile_bank`: one bank's row array, write port, full flag and count, with a set_full/release interface. Instantiated twice.
- The top of `pingpong_tile_buffer` holds the pointers, the handshakes and the mode-dependent read mux/mask (generate on `MODE`).

## Test plan
Bench parameters: `ROW_W=8`, `DEPTH=4`.

- **Parallel, full tile:** write 0x11,0x22,0x33,0x44 on consecutive cycles, `rd_ready=0`.
  - Required: `rd_valid=1` the cycle after the 4th write; `rd_data=0x44332211`; `rd_rows=4`.
  - Then `rd_ready=1` for 1 cycle: `rd_valid` drops.
- **Short tile, parallel:** write 0xA1,0xA2 with `wr_last` on the 2nd.
  - Required: `rd_rows=2`; `rd_data=0x0000A2A1`.
- **Drain mode:** fill bank0 with 1..4 and bank1 with 5..6 (`wr_last`), then hold `rd_ready=1`.
  - Required: `rd_data` 1,2,3,4,5,6 on consecutive cycles.
  - Required: `rd_last` high on 4 and on 6; `rd_rows` 4 then 2.
- **Backpressure/full:** fill 8 rows with `rd_ready=0`.
  - Required: `wr_ready=0` after the 8th row; a 9th row offered is not stored.
  - Release one bank: the 9th row is accepted the following cycle.
- **Concurrent:** sustained `wr_valid=1` and `rd_ready=1` for 40 cycles in parallel mode.
  - Required: 10 banks delivered in order; no row lost or duplicated (scoreboard).
- **Reset mid-fill:** after 3 writes into bank1 with bank0 full, assert `reset` for 1 cycle.
  - Required: all outputs at their reset values.
  - Next written tile: read back alone, starting at row 0.
